// File: rtl/alu_rs_pkg.sv
// Shared defines for the ALU reservation station: opcodes, ROB tag width and entry layout.
// Operand snooping is a helper so that dispatch and resident entries resolve tags identically.
package alu_rs_pkg;

  localparam int unsigned RobTagW = 4;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef struct packed {
    logic [31:0]        val;
    logic [RobTagW-1:0] tag;
    logic               busy;
  } operand_t;

  typedef struct packed {
    logic               busy;
    logic [6:0]         opcode;
    logic [2:0]         precise;
    logic               more_precise;
    logic [31:0]        imm;
    logic [31:0]        pc;
    operand_t           j;
    operand_t           k;
    logic [RobTagW-1:0] rob_entry;
  } rs_entry_t;

  typedef struct packed {
    logic [31:0]        a;
    logic [31:0]        b;
    logic [31:0]        pc;
    logic [31:0]        imm;
    logic [6:0]         opcode;
    logic [2:0]         precise;
    logic               more_precise;
    logic [RobTagW-1:0] rob_entry;
  } issue_t;

  // A pending operand takes the value of a matching broadcast; ALU bus wins if both match.
  function automatic operand_t snoop(operand_t op,
                                     logic alu_v, logic [RobTagW-1:0] alu_tag,
                                     logic [31:0] alu_val,
                                     logic lsb_v, logic [RobTagW-1:0] lsb_tag,
                                     logic [31:0] lsb_val);
    operand_t r;
    r = op;
    if (op.busy && alu_v && (alu_tag == op.tag)) begin
      r.val  = alu_val;
      r.busy = 1'b0;
    end else if (op.busy && lsb_v && (lsb_tag == op.tag)) begin
      r.val  = lsb_val;
      r.busy = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder used for both free-slot and ready-entry selection.
module rs_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]                       req,
  output logic                               valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch with CDB snooping, operand wake-up and
// lowest-index in-order issue into a registered output stage.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               rollback_config,
  input  logic               in_config,
  input  logic [6:0]         in_opcode,
  input  logic [2:0]         in_precise,
  input  logic               in_more_precise,
  input  logic [31:0]        in_imm,
  input  logic [31:0]        in_PC,
  input  logic [31:0]        in_vj,
  input  logic [31:0]        in_vk,
  input  logic [RobTagW-1:0] in_qj,
  input  logic [RobTagW-1:0] in_qk,
  input  logic               in_qj_busy,
  input  logic               in_qk_busy,
  input  logic [RobTagW-1:0] in_rob_entry,
  input  logic               alu_cdb_config,
  input  logic [RobTagW-1:0] alu_cdb_rob_entry,
  input  logic [31:0]        alu_cdb_val,
  input  logic               lsb_cdb_config,
  input  logic [RobTagW-1:0] lsb_cdb_rob_entry,
  input  logic [31:0]        lsb_cdb_val,
  output logic               out_full,
  output logic               out_config,
  output logic [31:0]        out_a,
  output logic [31:0]        out_b,
  output logic [31:0]        out_PC,
  output logic [31:0]        out_imm,
  output logic [6:0]         out_opcode,
  output logic [2:0]         out_precise,
  output logic               out_more_precise,
  output logic [RobTagW-1:0] out_rob_entry
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t entry_q [RS_SIZE];
  rs_entry_t entry_d [RS_SIZE];
  issue_t    iss_q, iss_d;
  logic      out_config_q, out_config_d;

  logic [RS_SIZE-1:0] busy_vec, ready_vec;
  logic               free_valid, iss_valid;
  logic [IdxW-1:0]    free_idx, iss_idx;
  operand_t           disp_j, disp_k;

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = entry_q[i].busy;
      ready_vec[i] = entry_q[i].busy && !entry_q[i].j.busy && !entry_q[i].k.busy;
    end
  end

  assign out_full = &busy_vec;

  rs_pick #(.N(RS_SIZE)) u_free_pick (
    .req   (~busy_vec),
    .valid (free_valid),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE)) u_ready_pick (
    .req   (ready_vec),
    .valid (iss_valid),
    .idx   (iss_idx)
  );

  always_comb begin
    disp_j = snoop('{val: in_vj, tag: in_qj, busy: in_qj_busy},
                   alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
                   lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val);
    disp_k = snoop('{val: in_vk, tag: in_qk, busy: in_qk_busy},
                   alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
                   lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val);
  end

  always_comb begin
    entry_d      = entry_q;
    iss_d        = iss_q;
    out_config_d = 1'b0;

    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (entry_q[i].busy) begin
        entry_d[i].j = snoop(entry_q[i].j, alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
                             lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val);
        entry_d[i].k = snoop(entry_q[i].k, alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
                             lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val);
      end
    end

    if (iss_valid) begin
      out_config_d       = 1'b1;
      iss_d.a            = entry_q[iss_idx].j.val;
      iss_d.b            = entry_q[iss_idx].k.val;
      iss_d.pc           = entry_q[iss_idx].pc;
      iss_d.imm          = entry_q[iss_idx].imm;
      iss_d.opcode       = entry_q[iss_idx].opcode;
      iss_d.precise      = entry_q[iss_idx].precise;
      iss_d.more_precise = entry_q[iss_idx].more_precise;
      iss_d.rob_entry    = entry_q[iss_idx].rob_entry;
      entry_d[iss_idx].busy = 1'b0;
    end

    // Free slot is chosen from registered busy bits, so a slot freed by issue waits a cycle.
    if (in_config && free_valid) begin
      entry_d[free_idx].busy         = 1'b1;
      entry_d[free_idx].opcode       = in_opcode;
      entry_d[free_idx].precise      = in_precise;
      entry_d[free_idx].more_precise = in_more_precise;
      entry_d[free_idx].imm          = in_imm;
      entry_d[free_idx].pc           = in_PC;
      entry_d[free_idx].j            = disp_j;
      entry_d[free_idx].k            = disp_k;
      entry_d[free_idx].rob_entry    = in_rob_entry;
    end

    if (rollback_config) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) entry_d[i].busy = 1'b0;
      iss_d        = iss_q;
      out_config_d = 1'b0;
    end

    if (!rdy) begin
      entry_d      = entry_q;
      iss_d        = iss_q;
      out_config_d = out_config_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) entry_q[i] <= '0;
      iss_q        <= '0;
      out_config_q <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      iss_q        <= iss_d;
      out_config_q <= out_config_d;
    end
  end

  assign out_config       = out_config_q;
  assign out_a            = iss_q.a;
  assign out_b            = iss_q.b;
  assign out_PC           = iss_q.pc;
  assign out_imm          = iss_q.imm;
  assign out_opcode       = iss_q.opcode;
  assign out_precise      = iss_q.precise;
  assign out_more_precise = iss_q.more_precise;
  assign out_rob_entry    = iss_q.rob_entry;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: expected issues are queued at dispatch and popped on out_config.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback_config, in_config;
  logic [6:0]  in_opcode;
  logic [2:0]  in_precise;
  logic        in_more_precise;
  logic [31:0] in_imm, in_PC, in_vj, in_vk;
  logic [3:0]  in_qj, in_qk, in_rob_entry;
  logic        in_qj_busy, in_qk_busy;
  logic        alu_cdb_config, lsb_cdb_config;
  logic [3:0]  alu_cdb_rob_entry, lsb_cdb_rob_entry;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        out_full, out_config, out_more_precise;
  logic [31:0] out_a, out_b, out_PC, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_precise;
  logic [3:0]  out_rob_entry;

  typedef struct {
    logic [31:0] a, b, imm, pc;
    logic [6:0]  op;
    logic [2:0]  pr;
    logic        mp;
    logic [3:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_rs #(.RS_SIZE(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .rollback_config   (rollback_config),
    .in_config         (in_config),
    .in_opcode         (in_opcode),
    .in_precise        (in_precise),
    .in_more_precise   (in_more_precise),
    .in_imm            (in_imm),
    .in_PC             (in_PC),
    .in_vj             (in_vj),
    .in_vk             (in_vk),
    .in_qj             (in_qj),
    .in_qk             (in_qk),
    .in_qj_busy        (in_qj_busy),
    .in_qk_busy        (in_qk_busy),
    .in_rob_entry      (in_rob_entry),
    .alu_cdb_config    (alu_cdb_config),
    .alu_cdb_rob_entry (alu_cdb_rob_entry),
    .alu_cdb_val       (alu_cdb_val),
    .lsb_cdb_config    (lsb_cdb_config),
    .lsb_cdb_rob_entry (lsb_cdb_rob_entry),
    .lsb_cdb_val       (lsb_cdb_val),
    .out_full          (out_full),
    .out_config        (out_config),
    .out_a             (out_a),
    .out_b             (out_b),
    .out_PC            (out_PC),
    .out_imm           (out_imm),
    .out_opcode        (out_opcode),
    .out_precise       (out_precise),
    .out_more_precise  (out_more_precise),
    .out_rob_entry     (out_rob_entry)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [6:0] op, input logic [2:0] pr, input logic mp,
                      input logic [31:0] vj, input logic [3:0] qj, input logic qjb,
                      input logic [31:0] vk, input logic [3:0] qk, input logic qkb,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    in_config = 1'b1; in_opcode = op; in_precise = pr; in_more_precise = mp;
    in_vj = vj; in_qj = qj; in_qj_busy = qjb;
    in_vk = vk; in_qk = qk; in_qk_busy = qkb;
    in_imm = imm; in_PC = pc; in_rob_entry = rob;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [6:0] op, input logic [2:0] pr,
                      input logic mp, input logic [3:0] rob);
    exp_t e;
    e.a = a; e.b = b; e.imm = imm; e.pc = pc; e.op = op; e.pr = pr; e.mp = mp; e.rob = rob;
    sb.push_back(e);
  endtask

  // Budget 0 demands the issue on the current sample; larger budgets allow waiting.
  task automatic expect_issue(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (out_config !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, ".cfg"}, {31'd0, out_config}, 32'd1);
    check({tag, ".sb_pending"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".a"}, out_a, e.a);
      check({tag, ".b"}, out_b, e.b);
      check({tag, ".imm"}, out_imm, e.imm);
      check({tag, ".pc"}, out_PC, e.pc);
      check({tag, ".op"}, {25'd0, out_opcode}, {25'd0, e.op});
      check({tag, ".prec"}, {28'd0, out_more_precise, out_precise}, {28'd0, e.mp, e.pr});
      check({tag, ".rob"}, {28'd0, out_rob_entry}, {28'd0, e.rob});
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rollback_config = 1'b0; in_config = 1'b0;
    in_opcode = '0; in_precise = '0; in_more_precise = 1'b0; in_imm = '0; in_PC = '0;
    in_vj = '0; in_vk = '0; in_qj = '0; in_qk = '0; in_qj_busy = 1'b0; in_qk_busy = 1'b0;
    in_rob_entry = '0;
    alu_cdb_config = 1'b0; alu_cdb_rob_entry = '0; alu_cdb_val = '0;
    lsb_cdb_config = 1'b0; lsb_cdb_rob_entry = '0; lsb_cdb_val = '0;
    tick(); tick();

    // Reset state
    check("rst.cfg", {31'd0, out_config}, 32'd0);
    check("rst.full", {31'd0, out_full}, 32'd0);
    check("rst.a", out_a, 32'd0);
    check("rst.rob", {28'd0, out_rob_entry}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADDI with ready operand issues on the edge after the dispatch edge
    disp(OpcOpImm, 3'd0, 1'b0, 32'd5, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd3, 32'h100, 4'd2);
    push(32'd5, 32'd0, 32'd3, 32'h100, OpcOpImm, 3'd0, 1'b0, 4'd2);
    tick();
    in_config = 1'b0;
    check("addi.early", {31'd0, out_config}, 32'd0);
    tick();
    expect_issue("addi", 0);
    tick();
    check("addi.drop_cfg", {31'd0, out_config}, 32'd0);
    check("addi.hold_a", out_a, 32'd5);

    // ADD waiting on tag 4, ALU broadcast two cycles later
    disp(OpcOp, 3'd0, 1'b0, 32'd0, 4'd4, 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 32'h104, 4'd3);
    push(32'h10, 32'd7, 32'd0, 32'h104, OpcOp, 3'd0, 1'b0, 4'd3);
    tick();
    in_config = 1'b0;
    tick();
    check("add.stall", {31'd0, out_config}, 32'd0);
    alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd4; alu_cdb_val = 32'h10;
    tick();
    alu_cdb_config = 1'b0;
    check("add.wake", {31'd0, out_config}, 32'd0);
    tick();
    expect_issue("add", 0);

    // Dispatch-time snoop of LSB CDB
    disp(OpcOp, 3'd0, 1'b0, 32'd1, 4'd0, 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 32'h108, 4'd4);
    lsb_cdb_config = 1'b1; lsb_cdb_rob_entry = 4'd7; lsb_cdb_val = 32'd9;
    push(32'd1, 32'd9, 32'd0, 32'h108, OpcOp, 3'd0, 1'b0, 4'd4);
    tick();
    in_config = 1'b0; lsb_cdb_config = 1'b0;
    tick();
    expect_issue("snoop", 0);

    // Both buses wake different operands in one cycle
    disp(OpcOp, 3'd5, 1'b1, 32'd0, 4'd1, 1'b1, 32'd0, 4'd2, 1'b1, 32'd0, 32'h10c, 4'd5);
    push(32'hAA, 32'hBB, 32'd0, 32'h10c, OpcOp, 3'd5, 1'b1, 4'd5);
    tick();
    in_config = 1'b0;
    alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd1; alu_cdb_val = 32'hAA;
    lsb_cdb_config = 1'b1; lsb_cdb_rob_entry = 4'd2; lsb_cdb_val = 32'hBB;
    tick();
    alu_cdb_config = 1'b0; lsb_cdb_config = 1'b0;
    tick();
    expect_issue("dualcdb", 0);

    // Fill all entries, drop a ninth, release exactly one
    for (int i = 0; i < 8; i++) begin
      disp(OpcBranch, 3'd0, 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'h100 + 32'(i), 4'd0, 1'b0,
           32'(i), 32'h200 + 32'(4 * i), 4'(i));
      tick();
    end
    check("fill.full", {31'd0, out_full}, 32'd1);
    disp(OpcJal, 3'd0, 1'b0, 32'd1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 32'h300, 4'd15);
    tick();
    in_config = 1'b0;
    check("fill.full2", {31'd0, out_full}, 32'd1);
    tick();
    check("fill.dropped", {31'd0, out_config}, 32'd0);
    alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd13; alu_cdb_val = 32'h55;
    push(32'h55, 32'h105, 32'd5, 32'h214, OpcBranch, 3'd0, 1'b0, 4'd5);
    tick();
    alu_cdb_config = 1'b0;
    check("fill.wake", {31'd0, out_config}, 32'd0);
    tick();
    expect_issue("fill", 0);
    check("fill.notfull", {31'd0, out_full}, 32'd0);
    tick();
    check("fill.one_only", {31'd0, out_config}, 32'd0);
    rollback_config = 1'b1;
    tick();
    rollback_config = 1'b0;
    check("flush1.full", {31'd0, out_full}, 32'd0);
    tick();
    check("flush1.cfg", {31'd0, out_config}, 32'd0);

    // Rollback beats issue of three ready entries
    for (int i = 0; i < 3; i++) begin
      disp(OpcAuipc, 3'd0, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 1'b0, 32'd0, 32'h400,
           4'(i + 1));
      tick();
    end
    in_config = 1'b0;
    alu_cdb_config = 1'b1; alu_cdb_rob_entry = 4'd9; alu_cdb_val = 32'd1;
    tick();
    alu_cdb_config = 1'b0;
    rollback_config = 1'b1;
    tick();
    rollback_config = 1'b0;
    check("rb.cfg", {31'd0, out_config}, 32'd0);
    check("rb.full", {31'd0, out_full}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rb.none", {31'd0, out_config}, 32'd0);
    end

    // rdy low freezes state and ignores dispatch
    disp(OpcOpImm, 3'd0, 1'b0, 32'h66, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd6, 32'h500, 4'd6);
    push(32'h66, 32'd0, 32'd6, 32'h500, OpcOpImm, 3'd0, 1'b0, 4'd6);
    tick();
    disp(OpcOpImm, 3'd0, 1'b0, 32'h77, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 32'h504, 4'd12);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_config = 1'b0;
      check("rdy.frozen", {31'd0, out_config}, 32'd0);
    end
    check("rdy.hold_a", out_a, 32'h55);
    rdy = 1'b1;
    tick();
    expect_issue("rdy", 0);
    tick();
    check("rdy.ignored", {31'd0, out_config}, 32'd0);

    // Issue and dispatch in the same cycle, in order
    disp(OpcOp, 3'd0, 1'b0, 32'hA1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 32'h600, 4'd1);
    push(32'hA1, 32'd0, 32'd0, 32'h600, OpcOp, 3'd0, 1'b0, 4'd1);
    tick();
    disp(OpcOp, 3'd0, 1'b0, 32'hB2, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 32'h604, 4'd2);
    push(32'hB2, 32'd0, 32'd0, 32'h604, OpcOp, 3'd0, 1'b0, 4'd2);
    tick();
    in_config = 1'b0;
    expect_issue("pipe1", 0);
    tick();
    expect_issue("pipe2", 0);
    tick();
    check("pipe.idle", {31'd0, out_config}, 32'd0);

    // Reset mid-operation drops a ready entry
    disp(OpcOpImm, 3'd0, 1'b0, 32'h88, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 32'h700, 4'd7);
    tick();
    in_config = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mrst.cfg", {31'd0, out_config}, 32'd0);
    check("mrst.a", out_a, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst.noissue", {31'd0, out_config}, 32'd0);
    check("mrst.full", {31'd0, out_full}, 32'd0);

    check("sb.empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two).
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have rdy  input  1  global enable; low freezes all state and outputs.
REQ-005 SHALL have rollback_config  input  1  misprediction flush.
REQ-006 SHALL have in_config  input  1  dispatch strobe.
REQ-007 SHALL have in_opcode/in_precise/in_more_precise  input  7/3/1  instruction decode fields.
REQ-008 SHALL have in_imm, in_PC  input  32 each  immediate, instruction PC.
REQ-009 SHALL have in_vj, in_vk  input  32 each  operand values, valid when not busy.
REQ-010 SHALL have in_qj, in_qk  input  4 each  producer ROB tags.
REQ-011 SHALL have in_qj_busy, in_qk_busy  input  1 each  operand still pending.
REQ-012 SHALL have in_rob_entry  input  4  destination ROB tag.
REQ-013 SHALL have alu_cdb_config/alu_cdb_rob_entry/alu_cdb_val  input  1/4/32  ALU result broadcast.
REQ-014 SHALL have lsb_cdb_config/lsb_cdb_rob_entry/lsb_cdb_val  input  1/4/32  load result broadcast.
REQ-015 SHALL have out_full  output  1  no free entry (combinational from state).
REQ-016 SHALL have out_config, out_a, out_b, out_PC, out_imm, out_opcode, out_precise, out_more_precise, out_rob_entry  output  1/32/32/32/32/7/3/1/4  registered issue to ALU.

Function
REQ-017 Each entry SHALL hold busy, decode fields, imm, PC, vj, qj, qj_busy, vk, qk, qk_busy, rob_entry.
REQ-018 Dispatch (in_config && !out_full) SHALL write the lowest-index free entry; in_config while out_full SHALL be dropped.
REQ-019 out_full SHALL equal 1 iff all RS_SIZE entries are busy, evaluated before same-cycle issue.
REQ-020 Dispatch SHALL snoop both CDBs the same cycle: pending tag matching a valid broadcast is stored ready with the broadcast value.
REQ-021 Each busy entry SHALL capture a valid broadcast whose tag matches a pending qj/qk, clearing that busy bit; both CDBs may match different operands in one cycle.
REQ-022 An entry SHALL be ready when busy && !qj_busy && !qk_busy in registered state; wake-up latency one cycle after broadcast.
REQ-023 Each cycle the lowest-index ready entry SHALL be issued: outputs registered next edge, out_config=1, entry freed same edge.
REQ-024 With no ready entry out_config SHALL be 0 next edge; other outputs hold.
REQ-025 An entry freed by issue SHALL not be reusable by dispatch in the same cycle.
REQ-026 Issue of one entry and dispatch into another SHALL both occur in one cycle.
REQ-027 rollback_config SHALL clear all busy bits and out_config next edge, overriding dispatch, capture and issue.
REQ-028 rdy low SHALL hold every register; dispatch and broadcasts that cycle are ignored.

Reset
REQ-029 rst_n low at an edge SHALL clear all busy bits and set every output register to 0, priority over rollback and rdy.
REQ-030 Reset mid-operation SHALL discard all entries with no issue the following cycle.

Structure
REQ-031 Opcode constants (OP, OP-IMM, BRANCH, JAL, AUIPC) and ROB tag width SHALL live in the shared defines package.
REQ-032 A priority-encoder sub-module, rs_pick, SHALL serve both free-slot and ready-entry selection.

Verification
REQ-033 Dispatch ADDI vj=5 not busy, imm=3, rob=2 -> next edge out_config=1, out_a=5, out_imm=3, out_rob_entry=2.
REQ-034 Dispatch ADD qj=4 busy; ALU CDB tag 4 val 0x10 two cycles later -> issue one cycle after broadcast with out_a=0x10.
REQ-035 Dispatch with qk=7 busy while LSB CDB tag 7 val 9 same cycle -> issued next edge with out_b=9.
REQ-036 Fill 8 stalled entries -> out_full=1; 9th in_config dropped; release one tag -> exactly that entry issues, out_full=0.
REQ-037 Three ready entries plus rollback_config=1 -> out_config=0 next edge, out_full=0, no later issue.
REQ-038 rdy=0 three cycles with ready entry -> outputs frozen; rdy=1 -> issue next edge.
